// File: rtl/alu_param.sv
// rtl/alu_param.sv - multi-cycle ALU: single-cycle logic/add/sub, Booth multiply, restoring divide.
module alu_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  input  logic [WIDTH-1:0]   A_divide,
  input  logic [2:0]         op,
  input  logic               BEGIN,
  output logic [2*WIDTH-1:0] OUT,
  output logic               END,
  output logic               BUSY,
  output logic               OVR,
  output logic               DIV0
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_x, r_y, r_a;
  logic [2:0]           r_op;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH:0]       r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_qm1;
  logic [2*WIDTH-1:0]   r_out;
  logic                 r_end, r_ovr, r_div0;

  logic                 w_start, w_long;
  logic [WIDTH:0]       w_m, w_bsum;
  logic [WIDTH:0]       w_shift, w_dsub;
  logic                 w_qbit;
  logic [WIDTH:0]       w_sum, w_diff;
  logic [2*WIDTH-1:0]   w_res;
  logic                 w_ovr, w_div0;

  // The END cycle is still IDLE, so BEGIN is refused there explicitly.
  assign w_start = (r_state == S_IDLE) && BEGIN && !r_end;
  assign w_long  = (op == OP_MUL) ||
                   ((op == OP_DIV) && (Y != '0) && (A_divide < Y));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = w_long ? S_EXEC : S_DONE;
      S_EXEC:  if (r_cnt == CNT_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Booth step: M sign-extended by one bit so A - M cannot overflow for M = -2^(W-1).
  assign w_m = {r_x[WIDTH-1], r_x};
  always_comb begin
    w_bsum = r_hi;
    case ({r_lo[0], r_qm1})
      2'b01:   w_bsum = r_hi + w_m;
      2'b10:   w_bsum = r_hi - w_m;
      default: w_bsum = r_hi;
    endcase
  end

  assign w_shift = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
  assign w_dsub  = w_shift - {1'b0, r_y};
  assign w_qbit  = (w_shift >= {1'b0, r_y});

  assign w_sum  = {1'b0, r_x} + {1'b0, r_y};
  assign w_diff = {1'b0, r_x} - {1'b0, r_y};

  always_comb begin
    w_res  = '0;
    w_ovr  = 1'b0;
    w_div0 = 1'b0;
    case (r_op)
      OP_AND: w_res[WIDTH-1:0] = r_x & r_y;
      OP_OR:  w_res[WIDTH-1:0] = r_x | r_y;
      OP_XOR: w_res[WIDTH-1:0] = r_x ^ r_y;
      OP_ADD: begin
        w_res[WIDTH:0] = w_sum;
        w_ovr = (r_x[WIDTH-1] == r_y[WIDTH-1]) && (w_sum[WIDTH-1] != r_x[WIDTH-1]);
      end
      OP_SUB: begin
        w_res[WIDTH:0] = w_diff;
        w_ovr = (r_x[WIDTH-1] != r_y[WIDTH-1]) && (w_diff[WIDTH-1] != r_x[WIDTH-1]);
      end
      OP_MUL: w_res = {r_hi[WIDTH-1:0], r_lo};
      OP_DIV: begin
        if (r_y == '0) begin
          w_res  = '1;
          w_ovr  = 1'b1;
          w_div0 = 1'b1;
        end else if (r_a >= r_y) begin
          w_res = '1;
          w_ovr = 1'b1;
        end else begin
          w_res = {r_hi[WIDTH-1:0], r_lo};
        end
      end
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x    <= '0;
      r_y    <= '0;
      r_a    <= '0;
      r_op   <= '0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_qm1  <= 1'b0;
      r_out  <= '0;
      r_end  <= 1'b0;
      r_ovr  <= 1'b0;
      r_div0 <= 1'b0;
    end else begin
      r_end <= (r_state == S_DONE);
      if (w_start) begin
        r_x   <= X;
        r_y   <= Y;
        r_a   <= A_divide;
        r_op  <= op;
        r_cnt <= CNT_INIT;
        r_qm1 <= 1'b0;
        if (op == OP_MUL) begin
          r_hi <= '0;
          r_lo <= Y;
        end else begin
          r_hi <= {1'b0, A_divide};
          r_lo <= X;
        end
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt - CNT_LAST;
        if (r_op == OP_MUL) begin
          r_hi  <= {w_bsum[WIDTH], w_bsum[WIDTH:1]};
          r_lo  <= {w_bsum[0], r_lo[WIDTH-1:1]};
          r_qm1 <= r_lo[0];
        end else begin
          r_hi <= w_qbit ? w_dsub : w_shift;
          r_lo <= {r_lo[WIDTH-2:0], w_qbit};
        end
      end else if (r_state == S_DONE) begin
        r_out  <= w_res;
        r_ovr  <= w_ovr;
        r_div0 <= w_div0;
      end
    end
  end

  assign OUT  = r_out;
  assign END  = r_end;
  assign BUSY = (r_state != S_IDLE);
  assign OVR  = r_ovr;
  assign DIV0 = r_div0;

endmodule

// File: doc/alu_param.md
ALU_PARAM -- requirements
Module: alu_param

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits, legal range 4..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: resetn  input  1  asynchronous active-low reset.
REQ-004 Port: X  input  WIDTH  operand A; low half of the dividend for DIV.
REQ-005 Port: Y  input  WIDTH  operand B; divisor for DIV.
REQ-006 Port: A_divide  input  WIDTH  high half of the dividend for DIV; ignored by other ops.
REQ-007 Port: op  input  3  000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 MUL, 110 DIV, 111 reserved.
REQ-008 Port: BEGIN  input  1  start request, sampled on clk.
REQ-009 Port: OUT  output  2*WIDTH  registered result.
REQ-010 Port: END  output  1  one-cycle completion pulse.
REQ-011 Port: BUSY  output  1  high while an operation is in progress.
REQ-012 Port: OVR  output  1  overflow or invalid-result flag, valid with END.
REQ-013 Port: DIV0  output  1  divide-by-zero flag, valid with END.

Function
REQ-014 FSM states SHALL be IDLE, EXEC and DONE; EXEC is used only by MUL and DIV.
REQ-015 In IDLE, BEGIN high at edge E0 SHALL latch X, Y, A_divide and op and set BUSY=1. Later input changes SHALL NOT affect the running operation.
REQ-016 BEGIN SHALL be ignored while BUSY=1.
REQ-017 AND, OR, XOR, ADD, SUB and reserved SHALL register OUT, flags and END=1 at E1. BUSY SHALL drop at E1.
REQ-018 Logic ops: OUT[WIDTH-1:0]=bitwise result; upper half = 0; OVR=0.
REQ-019 ADD: OUT[WIDTH:0]=X+Y unsigned, with carry in OUT[WIDTH] and remaining bits 0. OVR = two's-complement signed overflow.
REQ-020 SUB: OUT[WIDTH-1:0]=X-Y, OUT[WIDTH]=borrow (X<Y unsigned), remaining bits 0. OVR = signed overflow.
REQ-021 MUL: signed two's-complement radix-2 Booth, one iteration per cycle over WIDTH iterations (E1..EWIDTH). Result SHALL be registered with END at E(WIDTH+1). OUT = full 2*WIDTH signed product; OVR=0.
REQ-022 DIV: unsigned, dividend {A_divide,X}, divisor Y, one quotient bit per cycle over WIDTH iterations. Result at E(WIDTH+1) with OUT[WIDTH-1:0]=quotient and OUT[2*WIDTH-1:WIDTH]=remainder.
REQ-023 DIV with Y==0 SHALL skip EXEC and produce at E1: DIV0=1, OVR=1, OUT=all ones.
REQ-024 DIV with Y!=0 and A_divide>=Y (quotient overflow) SHALL skip EXEC and produce at E1: OVR=1, DIV0=0, OUT=all ones.
REQ-025 Reserved op: OUT=0, OVR=0, DIV0=0, END at E1.
REQ-026 The iteration counter SHALL be $clog2(WIDTH)+1 bits, SHALL count down from WIDTH, and SHALL leave EXEC at 0 with no wrap-around.
REQ-027 END SHALL be high for exactly one cycle, in DONE. The FSM SHALL then return to IDLE. BEGIN high in the END cycle SHALL be ignored; BEGIN is accepted from the following cycle.
REQ-028 OUT, OVR and DIV0 SHALL hold their values until the next accepted operation completes. They SHALL NOT change during EXEC.

Reset
REQ-029 resetn low SHALL asynchronously force IDLE and set OUT=0, END=0, BUSY=0, OVR=0, DIV0=0, counter=0 and all internal registers to 0.
REQ-030 Reset asserted during EXEC SHALL abort the operation with no END pulse. The first BEGIN after resetn rises SHALL be accepted normally.

Verification (WIDTH=8)
REQ-031 AND: X=0x11, Y=0x05, BEGIN pulse -> OUT=0x0001, END one cycle after BEGIN edge, OVR=0.
REQ-032 ADD: 0xFF+0x01 -> OUT=0x0100, OVR=0. ADD 0x7F+0x01 -> OUT=0x0080, OVR=1.
REQ-033 MUL: X=0xB9 (-71), Y=0x85 (-123) -> OUT=0x221D (8733), END at E9, BUSY high E0..E9.
REQ-034 DIV: A_divide=0x16, X=0x8B (5771), Y=0x87 (135) -> OUT=0x652A (R=101, Q=42), END at E9. Repeat with A_divide=0x1C, X=0x99, Y=0x53 -> OUT=0x1158 (R=17, Q=88).
REQ-035 DIV Y=0 -> DIV0=1, OVR=1, OUT=0xFFFF, END at E1. DIV A_divide=0x90, Y=0x80 -> OVR=1, DIV0=0, OUT=0xFFFF, END at E1.
REQ-036 Reset at E4 of a MUL -> all outputs 0, no END. BEGIN pulses during BUSY are ignored. A new AND after reset completes correctly.
